// File: rtl/bcd_scan_display.sv
// bcd_scan_display
// Multiplexed driver for a two-digit common-anode 7-segment display.
// The two BCD digits are latched once per frame (units slot, then tens slot). Each slot
// opens with a dark guard interval to suppress ghosting between digits.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous reset, active-low
//   seg0       in   [3:0] BCD units digit
//   seg1       in   [3:0] BCD tens digit
//   seg_n      out  [6:0] segment drive {g,f,e,d,c,b,a}, active-low
//   an_n       out  [1:0] digit enables, active-low; bit0 = units, bit1 = tens
//   frame_tick out  one-cycle pulse in the cycle after a new digit pair is latched
module bcd_scan_display #(
    parameter int unsigned REFRESH_DIV = 50000,  // cycles per digit slot, >= 2
    parameter int unsigned GUARD       = 500,    // dark cycles at slot start, < REFRESH_DIV
    parameter bit          BLANK_LZ    = 1'b1    // blank the tens digit when it is 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] seg0,
    input  logic [3:0] seg1,
    output logic [6:0] seg_n,
    output logic [1:0] an_n,
    output logic       frame_tick
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d;
    logic [7:0]    shadow_q;
    logic          loaded_q;
    logic          frame_tick_q;
    logic [6:0]    seg_n_q, seg_n_d;
    logic [1:0]    an_n_q, an_n_d;

    logic          wrap;
    logic          load;
    logic          in_guard;
    logic [3:0]    digit;
    logic          blank;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'h40;
            4'd1:    c = 7'h79;
            4'd2:    c = 7'h24;
            4'd3:    c = 7'h30;
            4'd4:    c = 7'h19;
            4'd5:    c = 7'h12;
            4'd6:    c = 7'h02;
            4'd7:    c = 7'h78;
            4'd8:    c = 7'h00;
            4'd9:    c = 7'h10;
            default: c = 7'h3F;  // non-BCD shows a dash
        endcase
        return c;
    endfunction

    assign wrap = (cnt_q == CNT_MAX);
    // First edge out of reset loads unconditionally; afterwards only at the end of the tens slot.
    assign load = !loaded_q || (wrap && sel_q);

    // A zero-length guard would make the compare constant, so it is elided entirely.
    if (GUARD == 0) begin : g_no_guard
        assign in_guard = 1'b0;
    end else begin : g_guard
        localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
        assign in_guard = (cnt_q < GUARD_C);
    end

    assign digit = sel_q ? shadow_q[7:4] : shadow_q[3:0];
    assign blank = BLANK_LZ && sel_q && (shadow_q[7:4] == 4'd0);

    always_comb begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        sel_d = sel_q ^ wrap;
    end

    // Outputs decode the current state and are registered, so they lag the state by a cycle.
    always_comb begin
        an_n_d  = 2'b11;
        seg_n_d = 7'h7F;
        if (loaded_q && !in_guard) begin
            an_n_d  = sel_q ? 2'b01 : 2'b10;
            seg_n_d = blank ? 7'h7F : seg_code(digit);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            sel_q        <= 1'b0;
            shadow_q     <= 8'h00;
            loaded_q     <= 1'b0;
            frame_tick_q <= 1'b0;
            an_n_q       <= 2'b11;
            seg_n_q      <= 7'h7F;
        end else begin
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            loaded_q     <= 1'b1;
            frame_tick_q <= load;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            if (load) begin
                shadow_q <= {seg1, seg0};
            end
        end
    end

    assign seg_n      = seg_n_q;
    assign an_n       = an_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display: three instances with different parameters share
// one stimulus stream. A reference model pushes the expected outputs for every clock edge
// into per-instance queues; a monitor pops and compares on the falling edge.
module tb_bcd_scan_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] seg0 = 4'd7;
    logic [3:0] seg1 = 4'd2;

    logic [6:0] seg_n_a, seg_n_b, seg_n_c;
    logic [1:0] an_n_a, an_n_b, an_n_c;
    logic       tick_a, tick_b, tick_c;

    typedef struct packed {
        logic [1:0] an;
        logic [6:0] seg;
        logic       tick;
    } exp_t;

    exp_t q_a[$], q_b[$], q_c[$];
    int compared = 0;
    int mismatched = 0;
    logic [6:0] code_tab [16];
    int n = 0;  // clock edges since reset release
    logic [7:0] sh_a = 8'h00, sh_b = 8'h00, sh_c = 8'h00;

    bcd_scan_display #(.REFRESH_DIV(8), .GUARD(2), .BLANK_LZ(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .seg0(seg0), .seg1(seg1),
        .seg_n(seg_n_a), .an_n(an_n_a), .frame_tick(tick_a)
    );
    bcd_scan_display #(.REFRESH_DIV(8), .GUARD(2), .BLANK_LZ(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .seg0(seg0), .seg1(seg1),
        .seg_n(seg_n_b), .an_n(an_n_b), .frame_tick(tick_b)
    );
    bcd_scan_display #(.REFRESH_DIV(2), .GUARD(0), .BLANK_LZ(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .seg0(seg0), .seg1(seg1),
        .seg_n(seg_n_c), .an_n(an_n_c), .frame_tick(tick_c)
    );

    always #5 clk = ~clk;

    // Expected outputs just after edge nn, given the digit pair held before that edge.
    // Edge 1 is the first after release; the display then shows state from edge nn-1 onwards.
    function automatic exp_t expect_out(input int d, input int g, input bit blz, input int nn,
                                        input logic [7:0] sh);
        exp_t e;
        int m, c, slot;
        e.an   = 2'b11;
        e.seg  = 7'h7F;
        e.tick = (nn == 1) || (nn > 0 && (nn % (2 * d)) == 0);
        if (nn >= 2) begin
            m    = nn - 1;
            c    = m % d;
            slot = (m / d) % 2;
            if (c >= g) begin
                if (slot == 0) begin
                    e.an  = 2'b10;
                    e.seg = code_tab[sh[3:0]];
                end else begin
                    e.an  = 2'b01;
                    e.seg = (blz && sh[7:4] == 4'd0) ? 7'h7F : code_tab[sh[7:4]];
                end
            end
        end
        return e;
    endfunction

    function automatic bit is_load(input int d, input int nn);
        return (nn == 1) || (nn > 0 && (nn % (2 * d)) == 0);
    endfunction

    task automatic check_out(input string nm, input exp_t exp, input exp_t act);
        compared++;
        if (exp !== act) begin
            mismatched++;
            $display("FAIL %s @%0t: got an=%b seg=%h tick=%b, need an=%b seg=%h tick=%b",
                     nm, $time, act.an, act.seg, act.tick, exp.an, exp.seg, exp.tick);
        end
    endtask

    task automatic check_inv(input string nm, input logic [1:0] an, input logic [6:0] seg);
        compared++;
        if (an == 2'b00 || (an == 2'b11 && seg !== 7'h7F)) begin
            mismatched++;
            $display("FAIL %s @%0t: got an=%b seg=%h, need one-hot-low an and dark seg when off",
                     nm, $time, an, seg);
        end
    endtask

    task automatic missing(input string nm);
        compared++;
        mismatched++;
        $display("FAIL %s @%0t: got no expected entry, need one per cycle", nm, $time);
    endtask

    // Reference model: one entry per clock edge per instance.
    initial begin
        forever begin
            @(posedge clk);
            n = rst_n ? n + 1 : 0;
            q_a.push_back(expect_out(8, 2, 1'b1, n, sh_a));
            q_b.push_back(expect_out(8, 2, 1'b0, n, sh_b));
            q_c.push_back(expect_out(2, 0, 1'b1, n, sh_c));
            if (is_load(8, n)) begin
                sh_a = {seg1, seg0};
                sh_b = {seg1, seg0};
            end
            if (is_load(2, n)) sh_c = {seg1, seg0};
        end
    end

    // Monitor: compare on the falling edge, plus invariants and frame_tick spacing.
    int cyc = 0;
    int ticks = 0;
    int last_tick = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check_out("out_a", e, {an_n_a, seg_n_a, tick_a});
            end else missing("out_a");
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check_out("out_b", e, {an_n_b, seg_n_b, tick_b});
            end else missing("out_b");
            if (q_c.size() > 0) begin
                e = q_c.pop_front();
                check_out("out_c", e, {an_n_c, seg_n_c, tick_c});
            end else missing("out_c");
            check_inv("inv_a", an_n_a, seg_n_a);
            check_inv("inv_c", an_n_c, seg_n_c);
            if (!rst_n) begin
                ticks = 0;
            end else if (tick_a) begin
                // First interval after reset is one short (load on the first edge), skip it.
                if (ticks >= 2) begin
                    compared++;
                    if (cyc - last_tick != 16) begin
                        mismatched++;
                        $display("FAIL tick_spacing @%0t: got %0d cycles, need 16",
                                 $time, cyc - last_tick);
                    end
                end
                ticks++;
                last_tick = cyc;
            end
        end
    end

    task automatic wait_cycles(input int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    initial begin
        int next_chg;
        bit found;
        code_tab[0] = 7'h40;  code_tab[1] = 7'h79;  code_tab[2] = 7'h24;  code_tab[3] = 7'h30;
        code_tab[4] = 7'h19;  code_tab[5] = 7'h12;  code_tab[6] = 7'h02;  code_tab[7] = 7'h78;
        code_tab[8] = 7'h00;  code_tab[9] = 7'h10;
        for (int i = 10; i < 16; i++) code_tab[i] = 7'h3F;

        // Reset and first load of 27.
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(40);

        // Decode sweep, one value per frame.
        seg1 = 4'd1;
        for (int i = 0; i < 10; i++) begin
            seg0 = 4'(i);
            wait_cycles(16);
        end

        // Leading zero (a blanks, b shows 0), then invalid BCD.
        seg1 = 4'd0;
        seg0 = 4'd5;
        wait_cycles(32);
        seg0 = 4'd12;
        wait_cycles(32);

        // Tearing: change units mid tens slot.
        seg1 = 4'd4;
        seg0 = 4'd3;
        wait_cycles(20);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (n % 16 == 12) found = 1'b1;
            else wait_cycles(1);
        end
        seg0 = 4'd8;
        wait_cycles(40);

        // Async reset at cnt = 5, sel = 1 of instance a, between edges.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (n % 16 == 13) found = 1'b1;
            else wait_cycles(1);
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL reset_slot_search: got no cnt=5 sel=1 slot, need one within 40 cycles");
        end
        rst_n = 1'b0;
        #1;
        check_out("async_rst_a", '{an: 2'b11, seg: 7'h7F, tick: 1'b0}, {an_n_a, seg_n_a, tick_a});
        check_out("async_rst_b", '{an: 2'b11, seg: 7'h7F, tick: 1'b0}, {an_n_b, seg_n_b, tick_b});
        check_out("async_rst_c", '{an: 2'b11, seg: 7'h7F, tick: 1'b0}, {an_n_c, seg_n_c, tick_c});
        seg1 = 4'd6;
        seg0 = 4'd9;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(40);

        // Randomized digit changes at random instants.
        next_chg = 0;
        for (int i = 0; i < 400; i++) begin
            if (i >= next_chg) begin
                seg0 = 4'($urandom_range(0, 15));
                seg1 = 4'($urandom_range(0, 15));
                next_chg = i + int'($urandom_range(1, 20));
            end
            wait_cycles(1);
        end

        wait_cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
